// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Pipelined immediate generator for the miniRISC decode stage. Expands a raw
// IMM_W-bit immediate field into a DATA_W operand according to in_mode
// (sign, zero, shift-amount, upper, scaled branch offset). A PREFIX beat
// latches the upper DATA_W-IMM_W bits for the next SEXT/ZEXT beat, which is
// then emitted fused. The result is registered behind a valid/ready handshake
// with no skid buffer.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   flush         synchronous pipeline flush (drops output and pending prefix)
//   in_valid      input beat valid
//   in_ready      block can accept a beat this cycle
//   in_mode       0 SEXT, 1 ZEXT, 2 SHAMT, 3 UPPER, 4 BRANCH, 5 PREFIX, 6-7 reserved
//   in_imm        raw immediate field
//   out_valid     out_imm valid
//   out_ready     consumer accepts output
//   out_imm       generated operand
//   out_prefixed  out_imm was built from latched prefix bits
//   out_err       beat carried a reserved mode
module imm_gen_pipe #(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 16,
    parameter int SHAMT_W   = 5,
    parameter int BR_SHIFT  = 0,
    parameter int PREFIX_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_prefixed,
    output logic              out_err
);

    // Number of bits a prefix contributes above the raw immediate.
    localparam int P = DATA_W - IMM_W;

    localparam logic [2:0] MODE_SEXT   = 3'd0;
    localparam logic [2:0] MODE_ZEXT   = 3'd1;
    localparam logic [2:0] MODE_SHAMT  = 3'd2;
    localparam logic [2:0] MODE_UPPER  = 3'd3;
    localparam logic [2:0] MODE_BRANCH = 3'd4;
    localparam logic [2:0] MODE_PREFIX = 3'd5;

    localparam logic STATE_IDLE     = 1'b0;
    localparam logic STATE_PREFIXED = 1'b1;

    logic              state;
    logic [P-1:0]      prefix_reg;
    logic              accept;
    logic              is_prefix;
    logic              fuse;
    logic [DATA_W-1:0] sext_val;
    logic [DATA_W-1:0] result;
    logic              result_err;

    // No skid buffer: a beat is taken only when the output slot is free or
    // draining this cycle, and never during a flush.
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_prefix = (PREFIX_EN != 0) && (in_mode == MODE_PREFIX);
    assign sext_val  = {{P{in_imm[IMM_W-1]}}, in_imm};

    // Only SEXT and ZEXT consume a pending prefix; other modes discard it.
    assign fuse = (state == STATE_PREFIXED) &&
                  ((in_mode == MODE_SEXT) || (in_mode == MODE_ZEXT));

    always_comb begin
        result     = '0;
        result_err = 1'b0;
        case (in_mode)
            MODE_SEXT:   result = fuse ? {prefix_reg, in_imm} : sext_val;
            MODE_ZEXT:   result = fuse ? {prefix_reg, in_imm} : {{P{1'b0}}, in_imm};
            MODE_SHAMT:  result = {{(DATA_W-SHAMT_W){1'b0}}, in_imm[IMM_W-1 -: SHAMT_W]};
            MODE_UPPER:  result = {in_imm, {P{1'b0}}};
            MODE_BRANCH: result = sext_val << BR_SHIFT;
            // Reserved modes, including PREFIX when prefixing is disabled.
            // When PREFIX is enabled this value is never registered.
            default:     result_err = 1'b1;
        endcase
    end

    // A prefix beat only updates the prefix state; the output slot may still
    // drain in the same cycle. Output registers change only on a non-prefix
    // accept, so they hold steady under backpressure and across a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_prefixed <= 1'b0;
            out_err      <= 1'b0;
            state        <= STATE_IDLE;
            prefix_reg   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= STATE_IDLE;
        end else if (accept && is_prefix) begin
            prefix_reg <= in_imm[P-1:0];
            state      <= STATE_PREFIXED;
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_imm      <= result;
            out_prefixed <= fuse;
            out_err      <= result_err;
            state        <= STATE_IDLE;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
// Testbench for imm_gen_pipe (DATA_W=32, IMM_W=16, SHAMT_W=5, BR_SHIFT=2).
// Walks the directed scenarios, then a randomized run, comparing every cycle
// against a transaction-level reference model built from plain arithmetic.
module tb_imm_gen_pipe;

    localparam int DATA_W   = 32;
    localparam int IMM_W    = 16;
    localparam int SHAMT_W  = 5;
    localparam int BR_SHIFT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_mode = 3'd0;
    logic [IMM_W-1:0]  in_imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_imm;
    logic              out_prefixed;
    logic              out_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the consumer should currently see.
    bit          m_valid  = 1'b0;
    logic [31:0] m_imm    = '0;
    bit          m_pref   = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_pend   = 1'b0;
    bit          m_known  = 1'b0;
    logic [15:0] m_prefix = '0;

    imm_gen_pipe #(
        .DATA_W(DATA_W), .IMM_W(IMM_W), .SHAMT_W(SHAMT_W),
        .BR_SHIFT(BR_SHIFT), .PREFIX_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_prefixed(out_prefixed), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Operand value from the mode rules, using signed integer arithmetic.
    function automatic void refValue(input logic [2:0] mode, input logic [15:0] imm,
                                     input bit pend, input logic [15:0] pre,
                                     output logic [31:0] val, output bit pf, output bit er);
        longint s;
        longint mask;
        mask = 64'hFFFF_FFFF;
        s    = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
        val  = '0;
        pf   = 1'b0;
        er   = 1'b0;
        case (mode)
            3'd0, 3'd1: begin
                if (pend) begin
                    val = 32'(longint'(pre) * 65536 + longint'(imm));
                    pf  = 1'b1;
                end else if (mode == 3'd0) begin
                    val = 32'(s & mask);
                end else begin
                    val = 32'(longint'(imm));
                end
            end
            3'd2:    val = 32'(longint'(imm) / 2048);
            3'd3:    val = 32'((longint'(imm) * 65536) & mask);
            3'd4:    val = 32'((s * (64'sd1 << BR_SHIFT)) & mask);
            default: er  = 1'b1;
        endcase
    endfunction

    task automatic checkOutput();
        check("out_valid", out_valid, m_valid);
        if (m_known) begin
            check("out_imm", out_imm, m_imm);
            check("out_prefixed", out_prefixed, m_pref);
            check("out_err", out_err, m_err);
        end
    endtask

    // Drives one cycle of inputs, checks in_ready, advances the model and
    // checks the registered outputs after the edge.
    task automatic applyStimulus(input bit r, input bit fl, input bit v,
                                 input logic [2:0] mode, input logic [15:0] imm,
                                 input bit ordy);
        bit          exp_rdy;
        bit          acc;
        logic [31:0] val;
        bit          pf;
        bit          er;
        @(negedge clk);
        rst = r; flush = fl; in_valid = v; in_mode = mode; in_imm = imm; out_ready = ordy;
        #1;
        exp_rdy = !fl && (!m_valid || ordy);
        check("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        if (r) begin
            m_valid = 0; m_imm = '0; m_pref = 0; m_err = 0;
            m_pend = 0; m_prefix = '0; m_known = 1;
        end else if (fl) begin
            m_valid = 0; m_pend = 0; m_known = 0;
        end else if (acc && mode == 3'd5) begin
            m_prefix = imm;
            m_pend   = 1;
            if (ordy) m_valid = 0;
        end else if (acc) begin
            refValue(mode, imm, m_pend, m_prefix, val, pf, er);
            m_imm = val; m_pref = pf; m_err = er;
            m_valid = 1; m_pend = 0; m_known = 1;
        end else if (ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        bit          r;
        bit          fl;
        bit          v;
        bit          ordy;
        logic [2:0]  mode;
        logic [15:0] imm;

        // Reset, then SEXT
        applyStimulus(1, 0, 0, 3'd0, 16'h0000, 1);
        applyStimulus(1, 0, 0, 3'd0, 16'h0000, 1);
        check("reset_valid", out_valid, 1'b0);
        check("reset_imm", out_imm, 32'h0);
        applyStimulus(0, 0, 1, 3'd0, 16'h8001, 1);
        check("plan_sext", out_imm, 32'hFFFF8001);
        check("plan_sext_pref", out_prefixed, 1'b0);

        // Mode sweep
        applyStimulus(0, 0, 1, 3'd1, 16'hF800, 1);
        check("plan_zext", out_imm, 32'h0000F800);
        applyStimulus(0, 0, 1, 3'd2, 16'hF800, 1);
        check("plan_shamt", out_imm, 32'h0000001F);
        applyStimulus(0, 0, 1, 3'd3, 16'hF800, 1);
        check("plan_upper", out_imm, 32'hF8000000);
        applyStimulus(0, 0, 1, 3'd4, 16'hF800, 1);
        check("plan_branch", out_imm, 32'hFFFFE000);
        applyStimulus(0, 0, 1, 3'd7, 16'hF800, 1);
        check("plan_rsvd_imm", out_imm, 32'h0);
        check("plan_rsvd_err", out_err, 1'b1);

        // Prefix fusion
        applyStimulus(0, 0, 1, 3'd5, 16'h1234, 1);
        check("plan_prefix_nobeat", out_valid, 1'b0);
        applyStimulus(0, 0, 1, 3'd1, 16'h5678, 1);
        check("plan_fused", out_imm, 32'h12345678);
        check("plan_fused_pref", out_prefixed, 1'b1);
        applyStimulus(0, 0, 1, 3'd1, 16'h0001, 1);
        check("plan_after_fuse", out_imm, 32'h00000001);
        check("plan_after_fuse_pref", out_prefixed, 1'b0);

        // Backpressure and back-to-back drain
        applyStimulus(0, 0, 0, 3'd0, 16'h0000, 1);
        applyStimulus(0, 0, 1, 3'd0, 16'h0005, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 3'd0, 16'h0099, 0);
            check("plan_hold", out_imm, 32'h00000005);
        end
        applyStimulus(0, 0, 1, 3'd1, 16'h0007, 1);
        check("plan_b2b", out_imm, 32'h00000007);

        // Flush mid-prefix
        applyStimulus(0, 0, 1, 3'd5, 16'hABCD, 1);
        applyStimulus(0, 1, 1, 3'd0, 16'h0010, 1);
        check("plan_flush_valid", out_valid, 1'b0);
        applyStimulus(0, 0, 1, 3'd0, 16'h0002, 1);
        check("plan_post_flush", out_imm, 32'h00000002);
        check("plan_post_flush_pref", out_prefixed, 1'b0);

        // Reset mid-operation
        applyStimulus(0, 0, 1, 3'd0, 16'h0044, 0);
        applyStimulus(1, 0, 1, 3'd5, 16'h7777, 0);
        check("plan_rst_valid", out_valid, 1'b0);
        check("plan_rst_imm", out_imm, 32'h0);
        applyStimulus(0, 0, 1, 3'd5, 16'h5555, 0);
        applyStimulus(1, 0, 0, 3'd0, 16'h0000, 0);
        applyStimulus(0, 0, 1, 3'd1, 16'h0003, 1);
        check("plan_rst_prefix", out_imm, 32'h00000003);
        check("plan_rst_prefix_pref", out_prefixed, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 49) == 0);
            fl   = ($urandom_range(0, 9) == 0);
            v    = ($urandom_range(0, 9) < 7);
            mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) mode = 3'd5;
            imm  = 16'($urandom);
            ordy = ($urandom_range(0, 9) < 6);
            applyStimulus(r, fl, v, mode, imm, ordy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
